// File: rtl/jb_pkg.sv
// Shared Joybus definitions: timing default, transmitter FSM states and
// well-known console command encodings.
package jb_pkg;

  // Default system clock cycles per microsecond.
  localparam int unsigned JB_CLKS_PER_US = 25;

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    STOP,
    WAIT
  } jb_state_e;

  localparam logic [7:0]  JB_CMD_PROBE    = 8'h00;
  localparam logic [7:0]  JB_CMD_N64_POLL = 8'h01;
  localparam logic [23:0] JB_CMD_GC_POLL  = 24'h400302;

endpackage

// File: rtl/jb_sync.sv
// Two-flop synchroniser for the asynchronous Joybus line level.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   d          - asynchronous input
//   q          - synchronised output (both flops reset to RESET_VAL)
module jb_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/joybus_tx.sv
// Console-side Joybus transmitter. Sends 1-3 command bytes MSB first as
// pulse-width coded bits, appends the console stop bit, then waits for the
// controller's first falling edge (rx_start) or a timeout (resp_timeout).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   tx_start      - request, sampled only while idle
//   tx_cmd        - command bytes, [23:16] sent first
//   tx_nbytes     - bytes to send (1..3), 0 ignores the request
//   JB_RX         - raw asynchronous line level
//   jb_drive_low  - registered open-drain pull-down enable
//   tx_busy       - high whenever not idle
//   rx_start      - one-cycle pulse at detected reply start
//   resp_timeout  - one-cycle pulse when the reply window expires
module joybus_tx
  import jb_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = JB_CLKS_PER_US,
  parameter int unsigned TIMEOUT_US  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [23:0] tx_cmd,
  input  logic [1:0]  tx_nbytes,
  input  logic        JB_RX,
  output logic        jb_drive_low,
  output logic        tx_busy,
  output logic        rx_start,
  output logic        resp_timeout
);

  localparam int unsigned BitCycles  = 4 * CLKS_PER_US;
  localparam int unsigned WaitCycles = TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned CycW       = $clog2(BitCycles);
  localparam int unsigned WaitW      = $clog2(WaitCycles);

  localparam logic [CycW-1:0]  CycLast  = CycW'(BitCycles - 1);
  localparam logic [CycW-1:0]  CycOneU  = CycW'(CLKS_PER_US);
  localparam logic [CycW-1:0]  CycThrU  = CycW'(3 * CLKS_PER_US);
  localparam logic [CycW-1:0]  StopLast = CycW'(CLKS_PER_US - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WaitCycles - 1);

  jb_state_e        state_q, state_d;
  logic [CycW-1:0]  cyc_q, cyc_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bits_left_q, bits_left_d;
  logic             drive_q, drive_d;
  logic             rx_start_q, rx_start_d;
  logic             timeout_q, timeout_d;
  logic             line_s, line_s_d;
  logic             line_fall;

  jb_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (JB_RX),
    .q     (line_s)
  );

  // Our own stop bit leaves line_s_d low on entry to WAIT, so it cannot
  // look like a reply edge.
  assign line_fall = line_s_d & ~line_s;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    wait_d      = '0;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    rx_start_d  = 1'b0;
    timeout_d   = 1'b0;
    drive_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_start && (tx_nbytes != 2'd0)) begin
          shift_d     = tx_cmd;
          bits_left_d = {tx_nbytes, 3'b000};
          cyc_d       = '0;
          state_d     = BIT;
        end
      end
      BIT: begin
        if (cyc_q == CycLast) begin
          shift_d     = {shift_q[22:0], 1'b0};
          bits_left_d = bits_left_q - 5'd1;
          cyc_d       = '0;
          state_d     = (bits_left_q == 5'd1) ? STOP : BIT;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      STOP: begin
        if (cyc_q == StopLast) begin
          cyc_d   = '0;
          state_d = WAIT;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      WAIT: begin
        // Edge takes priority over expiry in the same cycle.
        if (line_fall) begin
          rx_start_d = 1'b1;
          state_d    = IDLE;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line drive is computed from next state so the registered output lines
    // up with the state it belongs to.
    unique case (state_d)
      BIT:     drive_d = shift_d[23] ? (cyc_d < CycOneU) : (cyc_d < CycThrU);
      STOP:    drive_d = 1'b1;
      default: drive_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      wait_q      <= '0;
      shift_q     <= '0;
      bits_left_q <= '0;
      drive_q     <= 1'b0;
      rx_start_q  <= 1'b0;
      timeout_q   <= 1'b0;
      line_s_d    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      wait_q      <= wait_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      drive_q     <= drive_d;
      rx_start_q  <= rx_start_d;
      timeout_q   <= timeout_d;
      line_s_d    <= line_s;
    end
  end

  assign jb_drive_low = drive_q;
  assign tx_busy      = (state_q != IDLE);
  assign rx_start     = rx_start_q;
  assign resp_timeout = timeout_q;

endmodule

// File: tb/tb_joybus_tx.sv
// Directed bench for joybus_tx with an open-drain line model.
module tb_joybus_tx;
  import jb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_start;
  logic [23:0] tx_cmd;
  logic [1:0]  tx_nbytes;
  logic        ctrl_low;
  logic        jb_rx;
  logic        jb_drive_low;
  logic        tx_busy;
  logic        rx_start;
  logic        resp_timeout;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  logic busy_ok;
  logic shape_ok;

  // Open-drain line: low if either side pulls it down.
  assign jb_rx = ~(jb_drive_low | ctrl_low);

  joybus_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_start     (tx_start),
    .tx_cmd       (tx_cmd),
    .tx_nbytes    (tx_nbytes),
    .JB_RX        (jb_rx),
    .jb_drive_low (jb_drive_low),
    .tx_busy      (tx_busy),
    .rx_start     (rx_start),
    .resp_timeout (resp_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count cycles while jb_drive_low stays at lvl (bounded).
  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    while (jb_drive_low === lvl && n < 200) begin
      if (tx_busy !== 1'b1) busy_ok = 1'b0;
      step();
      n++;
    end
  endtask

  // Start a frame and decode it from pulse widths; returns at the first
  // released cycle after the stop bit.
  task automatic run_frame(input logic [23:0] cmd, input logic [1:0] n, input int inject,
                           output logic [23:0] dec, output int active);
    int lo, hi, more, t0;
    busy_ok   = 1'b1;
    shape_ok  = 1'b1;
    dec       = '0;
    tx_cmd    = cmd;
    tx_nbytes = n;
    tx_start  = 1'b1;
    step();
    tx_start  = 1'b0;
    tx_cmd    = 24'h0;
    chk("drive_first_cycle", {31'd0, jb_drive_low}, 32'd1);
    t0 = cycle;
    for (int b = 0; b < 8 * int'(n); b++) begin
      wait_level(1'b1, lo);
      hi = 0;
      if (b == inject) begin
        tx_cmd    = 24'hFFFFFF;
        tx_nbytes = 2'd1;
        tx_start  = 1'b1;
        step();
        tx_start  = 1'b0;
        hi        = 1;
      end
      wait_level(1'b0, more);
      hi += more;
      if (!((lo == 25 && hi == 75) || (lo == 75 && hi == 25))) shape_ok = 1'b0;
      dec = {dec[22:0], (lo == 25)};
    end
    wait_level(1'b1, lo);
    chk("stop_low_width", lo, 25);
    active = cycle - t0;
  endtask

  initial begin
    logic [23:0] dec;
    int          active;
    int          k;
    logic        flag;
    logic        to_seen;

    rst_n     = 1'b0;
    tx_start  = 1'b0;
    tx_cmd    = 24'h0;
    tx_nbytes = 2'd0;
    ctrl_low  = 1'b0;
    repeat (3) step();
    chk("reset_drive", {31'd0, jb_drive_low}, 32'd0);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    chk("reset_rx_start", {31'd0, rx_start}, 32'd0);
    chk("reset_timeout", {31'd0, resp_timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // N64 poll with a reply 50 cycles after release.
    run_frame({JB_CMD_N64_POLL, 16'hABCD}, 2'd1, -1, dec, active);
    chk("n64_decode", {24'd0, dec[7:0]}, 32'h01);
    chk("n64_shape", {31'd0, shape_ok}, 32'd1);
    chk("n64_busy", {31'd0, busy_ok}, 32'd1);
    chk("n64_active", active, 825);
    chk("wait_released", {31'd0, jb_drive_low}, 32'd0);
    flag = 1'b0;
    repeat (50) begin
      if (rx_start !== 1'b0 || resp_timeout !== 1'b0 || tx_busy !== 1'b1) flag = 1'b1;
      step();
    end
    chk("n64_no_false_trigger", {31'd0, flag}, 32'd0);
    ctrl_low = 1'b1;
    k = 0;
    while (rx_start !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("n64_rx_start_latency", k, 3);
    chk("n64_idle_after_reply", {31'd0, tx_busy}, 32'd0);
    chk("n64_no_timeout", {31'd0, resp_timeout}, 32'd0);
    step();
    chk("rx_start_single", {31'd0, rx_start}, 32'd0);
    ctrl_low = 1'b0;
    repeat (5) step();

    // GC poll with a second request mid-frame, then no reply.
    run_frame(JB_CMD_GC_POLL, 2'd3, 5, dec, active);
    chk("gc_decode", {8'd0, dec}, 32'h400302);
    chk("gc_active", active, 2425);
    chk("gc_shape", {31'd0, shape_ok}, 32'd1);
    chk("gc_busy", {31'd0, busy_ok}, 32'd1);
    flag = 1'b0;
    k    = 0;
    while (resp_timeout !== 1'b1 && k < 3000) begin
      if (rx_start !== 1'b0) flag = 1'b1;
      step();
      k++;
    end
    chk("timeout_latency", k, 2500);
    chk("timeout_no_rx_start", {31'd0, flag}, 32'd0);
    chk("timeout_idle", {31'd0, tx_busy}, 32'd0);
    step();
    chk("timeout_single", {31'd0, resp_timeout}, 32'd0);
    flag = 1'b0;
    repeat (20) begin
      if (jb_drive_low !== 1'b0 || tx_busy !== 1'b0) flag = 1'b1;
      step();
    end
    chk("no_queued_frame", {31'd0, flag}, 32'd0);

    // Zero-byte request is ignored.
    tx_cmd    = 24'hFFFFFF;
    tx_nbytes = 2'd0;
    tx_start  = 1'b1;
    step();
    tx_start  = 1'b0;
    flag = 1'b0;
    repeat (20) begin
      if (jb_drive_low !== 1'b0 || tx_busy !== 1'b0) flag = 1'b1;
      step();
    end
    chk("nbytes0_ignored", {31'd0, flag}, 32'd0);

    // Reset during byte 2.
    tx_cmd    = JB_CMD_GC_POLL;
    tx_nbytes = 2'd3;
    tx_start  = 1'b1;
    step();
    tx_start  = 1'b0;
    repeat (1101) step();
    chk("pre_reset_drive", {31'd0, jb_drive_low}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_drive_async", {31'd0, jb_drive_low}, 32'd0);
    chk("reset_busy_async", {31'd0, tx_busy}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    flag  = 1'b0;
    repeat (200) begin
      if (jb_drive_low !== 1'b0 || tx_busy !== 1'b0 || rx_start !== 1'b0 ||
          resp_timeout !== 1'b0) flag = 1'b1;
      step();
    end
    chk("post_reset_quiet", {31'd0, flag}, 32'd0);

    // Reply edge lands on the final wait cycle: edge wins.
    run_frame({JB_CMD_PROBE, 16'h0000}, 2'd1, -1, dec, active);
    chk("probe_decode", {24'd0, dec[7:0]}, 32'h00);
    flag = 1'b0;
    repeat (2497) begin
      if (rx_start !== 1'b0 || resp_timeout !== 1'b0) flag = 1'b1;
      step();
    end
    chk("expiry_pre_quiet", {31'd0, flag}, 32'd0);
    ctrl_low = 1'b1;
    k       = 0;
    to_seen = 1'b0;
    while (rx_start !== 1'b1 && k < 10) begin
      if (resp_timeout !== 1'b0) to_seen = 1'b1;
      step();
      k++;
    end
    chk("expiry_rx_start", k, 3);
    chk("expiry_timeout_now", {31'd0, resp_timeout}, 32'd0);
    chk("expiry_timeout_before", {31'd0, to_seen}, 32'd0);
    step();
    chk("expiry_timeout_after", {31'd0, resp_timeout}, 32'd0);
    chk("expiry_idle", {31'd0, tx_busy}, 32'd0);
    ctrl_low = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
